// File: rtl/sram_imem_pkg.sv
// rtl/sram_imem_pkg.sv - shared constants and types for the instruction SRAM arbiter
package sram_imem_pkg;

  localparam int DATA_WIDTH = 2;
  localparam int ADDR_WIDTH = 4;

  // Requester IDs as seen on rsp_id and in the arbiter's last-grant register
  localparam logic ID_FETCH = 1'b0;
  localparam logic ID_LOAD  = 1'b1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// rtl/sram_rr_arb2.sv - two-way round-robin arbiter between fetch (A) and loader (B)
module sram_rr_arb2
  import sram_imem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  logic last_grant;

  // When both ask, the requester not served most recently wins
  always_comb begin
    a_grant = en & a_valid & (~b_valid | (last_grant == ID_LOAD));
    b_grant = en & b_valid & (~a_valid | (last_grant == ID_FETCH));
  end

  // Track the latest winner; reset pretends B won last so A goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_LOAD;
    end else if (a_grant) begin
      last_grant <= ID_FETCH;
    end else if (b_grant) begin
      last_grant <= ID_LOAD;
    end
  end

endmodule

// File: rtl/sram_imem_arbiter.sv
// rtl/sram_imem_arbiter.sv - shares the single-port instruction SRAM between fetch and loader
module sram_imem_arbiter
  import sram_imem_pkg::*;
#(
  parameter int DATA_WIDTH     = sram_imem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = sram_imem_pkg::ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  run;
  logic                  a_grant;
  logic                  b_grant;
  logic                  accept;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  s1_valid;
  logic                  s1_id;
  logic                  s1_we;
  logic                  s2_valid;
  logic                  s2_id;
  logic                  s2_we;

  assign run         = (state == RUN);
  assign init_done   = run;
  assign a_req_ready = a_grant;
  assign b_req_ready = b_grant;

  sram_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (run),
    .a_valid (a_req_valid),
    .b_valid (b_req_valid),
    .a_grant (a_grant),
    .b_grant (b_grant)
  );

  // Mux the winning request onto the issue path; fetch is always a read
  always_comb begin
    accept    = a_grant | b_grant;
    acc_we    = b_grant & b_req_we;
    acc_addr  = b_grant ? b_req_addr : a_req_addr;
    acc_wdata = acc_we ? b_req_wdata : '0;
  end

  // Leave the clear sequence once the last address has been issued
  always_comb begin
    state_next = state;
    if ((state == INIT) && (init_cnt == LAST_ADDR)) begin
      state_next = RUN;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Clear address counter, walks every word once while clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Macro pin registers; addr/din hold when idle to avoid needless toggling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else if (state == INIT) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= 1'b0;
      sram_addr0 <= init_cnt;
      sram_din0  <= '0;
    end else if (accept) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= ~acc_we;
      sram_addr0 <= acc_addr;
      sram_din0  <= acc_wdata;
    end else begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
    end
  end

  // Two metadata stages matching the macro's sample edge and data-valid edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= ID_FETCH;
      s1_we    <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= ID_FETCH;
      s2_we    <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_id    <= b_grant ? ID_LOAD : ID_FETCH;
      s1_we    <= acc_we;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_we    <= s1_we;
    end
  end

  // Response register; read data captured from the macro, held between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= ID_FETCH;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= s2_valid;
      if (s2_valid) begin
        rsp_id <= s2_id;
        rsp_we <= s2_we;
        if (!s2_we) begin
          rsp_rdata <= sram_dout0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_imem_arbiter.sv
// tb/tb_sram_imem_arbiter.sv - self-checking bench for sram_imem_arbiter
module tb_sram_imem_arbiter;

  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst2_n;
  logic          a_req_valid, a_req_ready, b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] a_req_addr, b_req_addr, sram_addr0;
  logic [DW-1:0] b_req_wdata, rsp_rdata, sram_din0, sram_dout0;
  logic          rsp_valid, rsp_id, rsp_we, init_done, sram_csb0, sram_web0;

  logic          a_req_valid2, a_req_ready2, b_req_valid2, b_req_ready2, b_req_we2;
  logic [AW-1:0] a_req_addr2, b_req_addr2, sram_addr02;
  logic [DW-1:0] b_req_wdata2, rsp_rdata2, sram_din02;
  logic [DW-1:0] sram_dout02 = '0;
  logic          rsp_valid2, rsp_id2, rsp_we2, init_done2, sram_csb02, sram_web02;

  sram_imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  sram_imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .a_req_valid(a_req_valid2), .a_req_ready(a_req_ready2), .a_req_addr(a_req_addr2),
    .b_req_valid(b_req_valid2), .b_req_ready(b_req_ready2), .b_req_we(b_req_we2),
    .b_req_addr(b_req_addr2), .b_req_wdata(b_req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_we(rsp_we2), .rsp_rdata(rsp_rdata2),
    .init_done(init_done2), .sram_csb0(sram_csb02), .sram_web0(sram_web02),
    .sram_addr0(sram_addr02), .sram_din0(sram_din02), .sram_dout0(sram_dout02)
  );

  // Macro model: pins sampled at posedge, array accessed at the following negedge
  logic          m_csb, m_web;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] mem [DEPTH];
  bit            seeded;

  always @(posedge clk) begin
    m_csb  <= sram_csb0;
    m_web  <= sram_web0;
    m_addr <= sram_addr0;
    m_din  <= sram_din0;
  end

  always @(negedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
      seeded <= 1'b1;
    end else if (!m_csb) begin
      if (!m_web) mem[m_addr] <= m_din;
      else        sram_dout0  <= mem[m_addr];
    end
  end

  // Reference: in-order response queue, memory image, who was served last
  typedef struct {
    int            due;
    logic          id;
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic          bv;
    logic          bwe;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ea;
    logic          eb;
  } vec_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_last_b;
  bit            mon_en;
  int            cyc;
  int            n_cmp, n_bad;
  vec_t          tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_last_b = 1'b1;
    sbq.delete();
  endtask

  // Predict this cycle's grant and any due response, then record the new accept
  task automatic monitor();
    logic ea, eb;
    exp_t e;
    ea = a_req_valid & (!b_req_valid | ref_last_b);
    eb = b_req_valid & (!a_req_valid | !ref_last_b);
    check("ready_ab", 32'({a_req_ready, b_req_ready}), 32'({ea, eb}));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_id", 32'(rsp_id), 32'(e.id));
      check("rsp_we", 32'(rsp_we), 32'(e.we));
      if (!e.we) check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    if (ea | eb) begin
      e.due = cyc + 3;
      e.id  = eb;
      e.we  = eb & b_req_we;
      if (e.we) ref_mem[b_req_addr] = b_req_wdata;
      e.data = eb ? ref_mem[b_req_addr] : ref_mem[a_req_addr];
      sbq.push_back(e);
      ref_last_b = eb;
    end
  endtask

  // One clock: check at negedge, return 1 time unit after the posedge
  task automatic step();
    @(negedge clk);
    cyc++;
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  // Clear sequence: 16 zero-writes on 0..15 with readies low, then idle
  task automatic check_init();
    for (int k = 0; k < DEPTH; k++) begin
      step();
      check("init_csb0", 32'(sram_csb0), 32'd0);
      check("init_web0", 32'(sram_web0), 32'd0);
      check("init_addr0", 32'(sram_addr0), 32'(k));
      check("init_din0", 32'(sram_din0), 32'd0);
      check("init_rsp", 32'(rsp_valid), 32'd0);
      check("init_done_flag", 32'(init_done), 32'(k == DEPTH - 1));
      if (k < DEPTH - 1) check("init_ready", 32'({a_req_ready, b_req_ready}), 32'd0);
      else begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
    end
    step();
    check("post_init_csb0", 32'(sram_csb0), 32'd1);
    check("post_init_done", 32'(init_done), 32'd1);
  endtask

  function automatic vec_t mk(logic av, logic [AW-1:0] aa, logic bv, logic bwe,
                              logic [AW-1:0] ba, logic [DW-1:0] bd, logic ea, logic eb);
    vec_t v;
    v.av = av; v.aa = aa; v.bv = bv; v.bwe = bwe; v.ba = ba; v.bd = bd; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(0, 0, 1, 0, 7, 0, 0, 1);   // B read 7 -> cleared 00
    tbl[1] = mk(0, 0, 1, 1, 3, 2, 0, 1);   // B write 3 = 10
    tbl[2] = mk(1, 3, 0, 0, 0, 0, 1, 0);   // A read 3 -> 10
    tbl[3] = mk(0, 0, 1, 1, 0, 1, 0, 1);   // B write 0 = 01
    tbl[4] = mk(0, 0, 1, 1, 1, 3, 0, 1);   // B write 1 = 11
    tbl[5] = mk(0, 0, 1, 1, 2, 2, 0, 1);   // B write 2 = 10
    tbl[6] = mk(1, 2, 0, 0, 0, 0, 1, 0);   // A read 2, 1, 0
    tbl[7] = mk(1, 1, 0, 0, 0, 0, 1, 0);
    tbl[8] = mk(1, 0, 0, 0, 0, 0, 1, 0);
    tbl[9] = mk(0, 0, 1, 0, 3, 0, 0, 1);   // B read so A leads next
    for (int i = 0; i < 8; i++)            // both valid: A, B, A, B ...
      tbl[10 + i] = mk(1, AW'(i), 1, 0, AW'(i + 8), 0, ((i % 2) == 0), ((i % 2) == 1));

    n_cmp = 0; n_bad = 0; cyc = 0; mon_en = 0;
    rst_n = 1'b0; rst2_n = 1'b0;
    a_req_valid = 1'b1; a_req_addr = '0; b_req_valid = 1'b1; b_req_we = 1'b0;
    b_req_addr = '0; b_req_wdata = '0;
    a_req_valid2 = 1'b0; a_req_addr2 = '0; b_req_valid2 = 1'b0; b_req_we2 = 1'b0;
    b_req_addr2 = '0; b_req_wdata2 = '0;
    repeat (3) step();

    check("rst_csb0", 32'(sram_csb0), 32'd1);
    check("rst_web0", 32'(sram_web0), 32'd1);
    check("rst_addr0", 32'(sram_addr0), 32'd0);
    check("rst_din0", 32'(sram_din0), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_we, rsp_rdata}), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_ready", 32'({a_req_ready, b_req_ready}), 32'd0);
    check("rst_init_done_noclear", 32'(init_done2), 32'd1);

    rst_n = 1'b1;
    check_init();
    ref_reset();
    mon_en = 1;

    for (int i = 0; i < 18; i++) begin
      a_req_valid = tbl[i].av; a_req_addr = tbl[i].aa;
      b_req_valid = tbl[i].bv; b_req_we = tbl[i].bwe;
      b_req_addr = tbl[i].ba;  b_req_wdata = tbl[i].bd;
      #1;
      check($sformatf("vec%0d_ready", i), 32'({a_req_ready, b_req_ready}), 32'({tbl[i].ea, tbl[i].eb}));
      step();
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    repeat (4) step();
    check("drain_table", 32'(sbq.size()), 32'd0);

    for (int i = 0; i < 400; i++) begin
      a_req_valid = 1'($urandom_range(0, 1)); a_req_addr = AW'($urandom);
      b_req_valid = 1'($urandom_range(0, 1)); b_req_we = 1'($urandom);
      b_req_addr = AW'($urandom); b_req_wdata = DW'($urandom);
      step();
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    repeat (4) step();
    check("drain_random", 32'(sbq.size()), 32'd0);

    // Reset while an A read sits in stage 1
    a_req_valid = 1'b1; a_req_addr = 4'd5;
    #1;
    check("midrst_a_ready", 32'(a_req_ready), 32'd1);
    step();
    mon_en = 0;
    a_req_valid = 1'b0;
    check("midrst_issued", 32'(sram_csb0), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("midrst_csb0", 32'(sram_csb0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    check_init();
    ref_reset();
    mon_en = 1;
    for (int i = 0; i < 60; i++) begin
      a_req_valid = 1'($urandom_range(0, 1)); a_req_addr = AW'($urandom);
      b_req_valid = 1'($urandom_range(0, 1)); b_req_we = 1'($urandom);
      b_req_addr = AW'($urandom); b_req_wdata = DW'($urandom);
      step();
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    repeat (4) step();
    check("drain_after_reset", 32'(sbq.size()), 32'd0);

    // No-clear variant serves on the first cycle after reset
    rst2_n = 1'b1; a_req_valid2 = 1'b1; a_req_addr2 = 4'd9;
    #1;
    check("noclear_init_done", 32'(init_done2), 32'd1);
    check("noclear_a_ready", 32'(a_req_ready2), 32'd1);
    step();
    a_req_valid2 = 1'b0;
    check("noclear_csb0", 32'(sram_csb02), 32'd0);
    check("noclear_addr0", 32'(sram_addr02), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_imem_arbiter.md
Name: sram_imem_arbiter

Overview:
- Controller and arbiter for the single-port 16x2 OpenRAM instruction SRAM macro: shares its one RW port between the instruction-fetch requester (port A, read-only) and the program-loader/debug requester (port B, read/write).
- Drives the macro's registered-input pins: csb0/web0 active low, inputs sampled at posedge, array accessed at negedge.
- Pipelined: accepts one request per cycle, returns responses in order.
- Optionally clears the whole array after reset before serving requests.
- Sits between the core's fetch unit/loader and the SRAM macro instance.

Parameters:
- DATA_WIDTH, 2, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width; depth = 1<<ADDR_WIDTH.
- CLEAR_ON_RESET, 1, when 1, write 0 to every word after reset before accepting requests.

Ports:
- clk  in  1  single clock, also drives the macro's clk0.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid  in  1  fetch read request.
- a_req_ready  out  1  fetch request accepted this cycle.
- a_req_addr  in  ADDR_WIDTH  fetch address.
- b_req_valid  in  1  loader request.
- b_req_ready  out  1  loader request accepted this cycle.
- b_req_we  in  1  1 = write, 0 = read.
- b_req_addr  in  ADDR_WIDTH  loader address.
- b_req_wdata  in  DATA_WIDTH  loader write data.
- rsp_valid  out  1  response pulse; always accepted, no backpressure.
- rsp_id  out  1  0 = port A, 1 = port B.
- rsp_we  out  1  1 = write acknowledge; rsp_rdata is don't-care.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  clear sequence finished; requests may be accepted.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (async, immediate):
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
  - rsp_valid=0, rsp_id=0, rsp_we=0, rsp_rdata=0.
  - Pipeline valids=0; round-robin pointer favours A.
  - init_done = !CLEAR_ON_RESET; FSM = INIT if CLEAR_ON_RESET else RUN.
- FSM INIT:
  - Each cycle registers csb0=0, web0=0, addr0=cnt, din0=0; cnt counts 0..DEPTH-1.
  - After addr DEPTH-1 is issued: FSM=RUN and init_done=1 at the same edge.
  - Both readies are 0 throughout INIT. INIT writes generate no rsp.
- FSM RUN, arbitration:
  - grant_a = a_req_valid & (!b_req_valid | last_grant==B).
  - grant_b = b_req_valid & (!a_req_valid | last_grant==A).
  - x_req_ready = grant_x (combinational from the valids); at most one ready per cycle.
  - last_grant updates only on an accept.
- Issue, at accept edge E0:
  - Register sram pins: csb0=0, web0=!we (A is always read), addr0, din0 (0 for reads).
  - Stage-1 metadata set at E0: valid, id, we.
  - With no accept, csb0=1 and web0=1 are registered; addr0/din0 hold.
- Access: the macro samples pins at E1; array read/write happens at the following negedge; dout0 is valid from negedge+DELAY until E2+T_HOLD.
- Response:
  - Stage-2 metadata is taken from stage 1 at E1.
  - At E2: rsp_valid=stage2.valid, rsp_id, rsp_we; rsp_rdata = sram_dout0 sampled at E2 for reads, held otherwise.
  - rsp_valid is a one-cycle pulse per request; fixed latency 2 edges after the accept edge.
- Throughput: back-to-back accepts every cycle. Responses strictly in issue order.
- Read-after-write to the same address on consecutive accepts returns the new data; no hazard logic is needed because the macro writes at the negedge before the following sample.
- Both valid every cycle: grants alternate A, B, A, B.
- Reset mid-operation: in-flight requests are dropped with no rsp; csb0 deasserts immediately; INIT restarts from addr 0.
- rsp_rdata holds its value between responses.

Decomposition:
- Shared package sram_imem_pkg: DATA_WIDTH/ADDR_WIDTH defaults, requester ID constants (ID_FETCH=0, ID_LOAD=1), FSM state enum (INIT, RUN).
- One natural sub-module, sram_rr_arb2: 2-way round-robin arbiter (valids in, grants out, last-grant register).
- Pin/pipeline registers and the FSM stay in the top module.

Test Plan:
- CLEAR_ON_RESET=1, release reset: exactly 16 write cycles on addr 0..15 with din0=0, then init_done=1; readies stay 0 throughout; B read of addr 7 then returns rsp_rdata=2'b00.
- B write addr 3 = 2'b10, next cycle A read addr 3: two rsp pulses in order; second has rsp_id=0, rsp_rdata=2'b10, arriving 2 edges after its accept.
- A and B valid continuously for 8 cycles: accepts alternate A, B, A, B; rsp_id sequence 0,1,0,1,... with one rsp per cycle, no gaps.
- Write 2'b01, 2'b11, 2'b10 to addr 0, 1, 2 via B; A reads 2, 1, 0 back-to-back: rsp_rdata 2'b10, 2'b11, 2'b01.
- Assert rst_n low during the cycle an A read is in stage 1: sram_csb0=1 immediately, no rsp emitted, INIT restarts at addr 0.
- CLEAR_ON_RESET=0: init_done=1 directly out of reset; an A request on the first cycle gets a_req_ready=1 and sram_csb0=0 at the next edge.
